// File: rtl/mem_burst_ctrl.sv
// mem_burst_ctrl: cache line fill/writeback burst controller.
// A combined request does the writeback first, idles one cycle, then does the fill.
module mem_burst_ctrl #(
   parameter int BURST_LEN = 4,
   parameter int LINE_W    = BURST_LEN * 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              REQ_RD,
   input  logic              REQ_WR,
   input  logic [31:0]       REQ_ADDR,
   input  logic [31:0]       REQ_WB_ADDR,
   input  logic [LINE_W-1:0] LINE_WDATA,
   output logic [LINE_W-1:0] LINE_RDATA,
   output logic              BUSY,
   output logic              DONE,
   output logic              MEM_RE,
   output logic              MEM_WE,
   output logic [31:0]       MEM_ADDR,
   output logic [31:0]       MEM_DATA_IN,
   input  logic [31:0]       MEM_DOUT,
   input  logic              MEM_VALID
);
   localparam int LB = $clog2(BURST_LEN);
   typedef enum logic [2:0] {IDLE, WR_BURST, GAP, RD_BURST, RESP} state_t;
   state_t            state;
   logic [LB-1:0]     beat, nxt_beat;
   logic [31:0]       wb_base, rd_base, wb_al, rd_al;
   logic [LINE_W-1:0] wline;
   logic              fill_pend, last;
   assign nxt_beat = beat + 1'b1;
   assign last     = beat == LB'(BURST_LEN - 1);
   assign wb_al    = {REQ_WB_ADDR[31:LB], {LB{1'b0}}};
   assign rd_al    = {REQ_ADDR[31:LB], {LB{1'b0}}};
   always_ff @(posedge CLK) begin
      if (RST) begin
         state       <= IDLE;
         beat        <= '0;
         wb_base     <= '0;
         rd_base     <= '0;
         wline       <= '0;
         fill_pend   <= 1'b0;
         LINE_RDATA  <= '0;
         BUSY        <= 1'b0;
         DONE        <= 1'b0;
         MEM_RE      <= 1'b0;
         MEM_WE      <= 1'b0;
         MEM_ADDR    <= '0;
         MEM_DATA_IN <= '0;
      end else begin
         case (state)
            IDLE: begin
               DONE <= 1'b0;
               beat <= '0;
               if (REQ_WR || REQ_RD) begin
                  wb_base   <= wb_al;
                  rd_base   <= rd_al;
                  wline     <= LINE_WDATA;
                  fill_pend <= REQ_RD;
                  BUSY      <= 1'b1;
               end
               if (REQ_WR) begin
                  state       <= WR_BURST;
                  MEM_WE      <= 1'b1;
                  MEM_ADDR    <= wb_al;
                  MEM_DATA_IN <= LINE_WDATA[31:0];
               end else if (REQ_RD) begin
                  state    <= RD_BURST;
                  MEM_RE   <= 1'b1;
                  MEM_ADDR <= rd_al;
               end
            end
            WR_BURST: if (MEM_VALID) begin
               if (last) begin
                  MEM_WE <= 1'b0;
                  beat   <= '0;
                  state  <= fill_pend ? GAP : RESP;
                  DONE   <= !fill_pend;
               end else begin
                  beat        <= nxt_beat;
                  MEM_ADDR    <= {wb_base[31:LB], nxt_beat};
                  MEM_DATA_IN <= wline[nxt_beat*32 +: 32];
               end
            end
            // Both enables stay low here for one cycle so memory re-arms before the fill.
            GAP: begin
               state     <= RD_BURST;
               fill_pend <= 1'b0;
               beat      <= '0;
               MEM_RE    <= 1'b1;
               MEM_ADDR  <= rd_base;
            end
            RD_BURST: if (MEM_VALID) begin
               LINE_RDATA[beat*32 +: 32] <= MEM_DOUT;
               if (last) begin
                  MEM_RE <= 1'b0;
                  beat   <= '0;
                  state  <= RESP;
                  DONE   <= 1'b1;
               end else begin
                  beat     <= nxt_beat;
                  MEM_ADDR <= {rd_base[31:LB], nxt_beat};
               end
            end
            RESP: begin
               DONE  <= 1'b0;
               BUSY  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
